// File: rtl/sync_debounce.sv
// Per-bit debounce with registered rise/fall pulses, placed after the input synchronizer.
// A bit's level flips only after DEB_CYCLES consecutive qualified samples disagree with it.
module sync_debounce #(
    parameter int WIDTH      = 4,
    parameter int DEB_CYCLES = 4
) (
    input  logic             Clk_i,
    input  logic             Rst_ni,
    input  logic             Tick_i,
    input  logic [WIDTH-1:0] Sync_si,
    output logic [WIDTH-1:0] Deb_so,
    output logic [WIDTH-1:0] Rise_so,
    output logic [WIDTH-1:0] Fall_so
);
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;

    always_comb begin
        deb_d  = deb_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (Tick_i) begin
                // Any agreeing sample throws away the partial count.
                if (Sync_si[i] == deb_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i]  = Sync_si[i];
                    cnt_d[i]  = '0;
                    rise_d[i] = Sync_si[i];
                    fall_d[i] = ~Sync_si[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            deb_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            deb_q  <= deb_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign Deb_so  = deb_q;
    assign Rise_so = rise_q;
    assign Fall_so = fall_q;

endmodule

// File: tb/tb_sync_debounce.sv
// Bench for sync_debounce: a DEB_CYCLES=4 and a DEB_CYCLES=1 instance checked against
// a history-based model (accept when the last N qualified samples all disagree with the level).
module tb_sync_debounce;
    localparam int N_A = 4;
    localparam int N_B = 1;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic [3:0] s4, s1;
    logic [3:0] deb4, rise4, fall4;
    logic [3:0] deb1, rise1, fall1;

    int total = 0;
    int bad   = 0;

    logic [3:0] m_lvl  [2];
    logic [3:0] m_rise [2];
    logic [3:0] m_fall [2];
    logic [3:0] hist0 [$];
    logic [3:0] hist1 [$];

    sync_debounce #(.WIDTH(4), .DEB_CYCLES(N_A)) dut_a (
        .Clk_i   (clk),
        .Rst_ni  (rst_n),
        .Tick_i  (tick),
        .Sync_si (s4),
        .Deb_so  (deb4),
        .Rise_so (rise4),
        .Fall_so (fall4)
    );

    sync_debounce #(.WIDTH(4), .DEB_CYCLES(N_B)) dut_b (
        .Clk_i   (clk),
        .Rst_ni  (rst_n),
        .Tick_i  (tick),
        .Sync_si (s1),
        .Deb_so  (deb1),
        .Rise_so (rise1),
        .Fall_so (fall1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // reference model
    function automatic logic run_ok(input logic [3:0] q[$], input int n, input int b,
                                    input logic lvl);
        logic [3:0] e;
        if (q.size() < n) return 1'b0;
        for (int k = 0; k < n; k++) begin
            e = q[q.size() - 1 - k];
            if (e[b] == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_lvl[d]  = '0;
            m_rise[d] = '0;
            m_fall[d] = '0;
        end
        hist0.delete();
        hist1.delete();
    endtask

    task automatic model_edge(input int d, input logic tk, input logic [3:0] s);
        logic [3:0] q [$];
        int         n;
        n = (d == 0) ? N_A : N_B;
        m_rise[d] = '0;
        m_fall[d] = '0;
        if (tk) begin
            if (d == 0) begin
                hist0.push_back(s);
                if (hist0.size() > 8) void'(hist0.pop_front());
                q = hist0;
            end else begin
                hist1.push_back(s);
                if (hist1.size() > 8) void'(hist1.pop_front());
                q = hist1;
            end
            for (int b = 0; b < 4; b++) begin
                if (run_ok(q, n, b, m_lvl[d][b])) begin
                    m_lvl[d][b]  = s[b];
                    m_rise[d][b] = s[b];
                    m_fall[d][b] = ~s[b];
                end
            end
        end
    endtask

    task automatic check_all();
        check("deb_a",  deb4,  m_lvl[0]);
        check("rise_a", rise4, m_rise[0]);
        check("fall_a", fall4, m_fall[0]);
        check("excl_a", rise4 & fall4, 4'h0);
        check("deb_b",  deb1,  m_lvl[1]);
        check("rise_b", rise1, m_rise[1]);
        check("fall_b", fall1, m_fall[1]);
        check("excl_b", rise1 & fall1, 4'h0);
    endtask

    // driver: apply inputs, take one edge, advance the model, compare 1 unit later
    task automatic step(input logic tk, input logic [3:0] a, input logic [3:0] b);
        tick = tk;
        s4   = a;
        s1   = b;
        @(posedge clk);
        model_edge(0, tk, a);
        model_edge(1, tk, b);
        #1;
        check_all();
    endtask

    initial begin
        int         cnt;
        logic [3:0] cur;

        rst_n = 1'b0;
        tick  = 1'b0;
        s4    = '0;
        s1    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        #2 rst_n = 1'b1;

        // clean step on bit 0
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 4'b0001, ~s1);
            if (k == 3) check("clean_pre", deb4, 4'b0000);
            if (k == 4) check("clean_rise", rise4, 4'b0001);
            if (k == 5) check("clean_after", rise4, 4'b0000);
        end

        // bounce on bit 1
        begin
            logic [7:0] pat;
            pat = 8'b1111_0111;
            cnt = 0;
            for (int k = 0; k < 8; k++) begin
                step(1'b1, {2'b00, pat[k], 1'b1}, ~s1);
                cnt += int'(rise4[1]);
                if (k == 6) check("bounce_hold", deb4, 4'b0001);
            end
            check("bounce_deb", deb4, 4'b0011);
            check("bounce_pulses", 4'(cnt), 4'd1);
        end

        // tick gating on bit 2
        repeat (4) step(1'b1, 4'b0111, ~s1);
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            step((k % 3) == 0, 4'b0011, ~s1);
            cnt += int'(fall4[2]);
            if (k == 8) check("gate_hold", deb4, 4'b0111);
        end
        check("gate_deb", deb4, 4'b0011);
        check("gate_pulses", 4'(cnt), 4'd1);

        // simultaneous accept on bits 0 and 2 with bit 3 glitching
        repeat (4) step(1'b1, 4'b0000, ~s1);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, {1'(k % 2), 3'b101}, ~s1);
            if (k == 3) check("multi_rise", rise4, 4'b0101);
        end
        check("multi_deb", deb4, 4'b0101);

        // randomized traffic with sticky levels
        cur = s4;
        for (int k = 0; k < 400; k++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) cur[b] = ~cur[b];
            end
            step($urandom_range(0, 3) != 0, cur, 4'($urandom));
        end

        // async reset in the middle of a count
        repeat (4) step(1'b1, 4'hF, ~s1);
        check("rst_pre", deb4, 4'hF);
        repeat (2) step(1'b1, 4'h0, ~s1);
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        check("rst_async", deb4, 4'h0);
        tick = 1'b1;
        s4   = 4'hF;
        @(posedge clk);
        #1;
        check_all();
        #2 rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 4'hF, ~s1);
            if (k == 3) check("rst_count", deb4, 4'h0);
            if (k == 4) check("rst_rise", rise4, 4'hF);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_debounce.md
Name: sync_debounce

Overview:
- Per-bit debounce and edge-detect stage directly downstream of the 2-flop input synchronizer of the general-purpose FSM controller.
- Takes the synchronized sensor/control vector and filters it per bit. A bit's output changes only after its input has differed from it for DEB_CYCLES consecutive qualified samples.
- Produces the clean level plus one-cycle rise and fall pulses, which the FSM next-state logic consumes as qualified sensor inputs.

Parameters:
- WIDTH, 4, number of input bits; equals `NIN+1 in the controller build.
- DEB_CYCLES, 4, consecutive differing qualified samples needed to accept a new level; legal range 1..255.
- CNT_W (localparam), $clog2(DEB_CYCLES+1), width of each per-bit stability counter.

Ports:
- Clk_i  input  1  system clock; all state updates on the rising edge.
- Rst_ni  input  1  asynchronous assert, active-low reset; release is synchronous to Clk_i.
- Tick_i  input  1  sample qualifier (prescaler strobe); tie high to sample every clock.
- Sync_si  input  WIDTH  synchronized inputs from the synchronizer stage.
- Deb_so  output  WIDTH  debounced level per bit.
- Rise_so  output  WIDTH  one-cycle pulse when Deb_so[i] goes 0->1.
- Fall_so  output  WIDTH  one-cycle pulse when Deb_so[i] goes 1->0.

Behaviour:
- Interface: one clock, Clk_i. Reset Rst_ni is asynchronous and active-low.
- Reset values:
  - Deb_so = 0, Rise_so = 0, Fall_so = 0.
  - All counters = 0.
  - Reset assertion mid-count discards the partial count immediately.
- Bits are fully independent; one counter cnt[i] per bit. At each rising edge:
  - Tick_i=0:
    - cnt[i] and Deb_so[i] hold.
    - Rise_so[i] and Fall_so[i] are cleared to 0.
  - Tick_i=1 and Sync_si[i]==Deb_so[i]:
    - cnt[i] <= 0.
    - Pulses <= 0.
  - Tick_i=1, Sync_si[i]!=Deb_so[i], and cnt[i]==DEB_CYCLES-1 (accept):
    - Deb_so[i] <= Sync_si[i].
    - cnt[i] <= 0.
    - Rise_so[i] <= Sync_si[i]; Fall_so[i] <= ~Sync_si[i].
  - Tick_i=1, Sync_si[i]!=Deb_so[i], and cnt[i]<DEB_CYCLES-1:
    - cnt[i] <= cnt[i]+1.
    - Pulses <= 0.
- Latency:
  - With Tick_i=1 and a clean step on Sync_si[i], Deb_so[i] changes on the DEB_CYCLES-th rising edge that samples the new value.
  - Rise_so[i] or Fall_so[i] is asserted in the same cycle Deb_so[i] changes.
- Pulse rules:
  - Pulses are registered and are high for exactly one Clk_i cycle, regardless of Tick_i spacing.
  - Rise_so[i] and Fall_so[i] are never high together.
- Glitch rejection: any qualified sample equal to Deb_so[i] before acceptance restarts the count from 0. There is no partial credit.
- DEB_CYCLES=1: the first qualified differing sample is accepted; input passes through with one flop of delay.
- The counter never exceeds DEB_CYCLES-1, so no wrap-around is possible.
- Simultaneous events: multiple bits may accept in the same edge; each asserts its own pulse.
- Outputs are driven directly from flops; there is no combinational path from Sync_si to any output.

Test Plan:
- Reset: assert Rst_ni=0 mid-count with Sync_si=4'hF -> all outputs 0 immediately (asynchronous). After release, Deb_so=4'hF on the 4th edge; Rise_so=4'hF for 1 cycle.
- Clean step, DEB_CYCLES=4, Tick_i=1: Sync_si[0] 0->1 sampled at edge N -> Deb_so[0]=1 and Rise_so[0]=1 after edge N+3. Rise_so[0]=0 after edge N+4. Fall_so stays 0.
- Bounce: Sync_si[1] pattern 1,1,1,0,1,1,1,1 (Deb_so[1]=0) -> no change through the glitch. Deb_so[1]=1 after the 8th sample. Exactly one Rise_so[1] pulse.
- Tick gating: Tick_i high every 3rd clock, Sync_si[2] 1->0 with Deb_so[2]=1 -> Deb_so[2] falls on the 4th qualified tick. Fall_so[2] is high for 1 clock only. cnt holds between ticks.
- Multi-bit simultaneous: Sync_si 4'b0000->4'b0101 plus bit 3 glitching -> bits 0 and 2 accept in the same cycle, Rise_so=4'b0101, bit 3 unchanged.
- DEB_CYCLES=1 build: Sync_si toggles every clock -> Deb_so follows with 1-cycle delay. Rise_so and Fall_so alternate each cycle and are never both high.
